approx_mult_pipe: RTL and testbench

- Parametrised, 2-stage pipelined unsigned WxW multiplier with a per-transaction mode: exact or approximate (truncated low rows).
- Approximate mode forms the exact product of y with x[W-1:L]. The L low partial-product rows keep only their bits at or above column KEEP_COL.
- The block adds valid/ready handshaking with backpressure and a sideband tag. A saturating mismatch counter gives the error-characterisation runs on-line statistics.

---
 rtl/approx_mult_pipe_if.sv | 32 +++
 rtl/approx_mult_pipe.sv | 135 +++++++++++++
 tb/tb_approx_mult_pipe.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/approx_mult_pipe_if.sv
// Handshake and data bundle for approx_mult_pipe.
// master = producer/consumer side (drives operands, consumes results),
// slave  = the multiplier pipeline itself.
interface approx_mult_pipe_if #(
    parameter int W     = 8,
    parameter int TAG_W = 4,
    parameter int CNT_W = 16
);
    logic               in_valid;
    logic               in_ready;
    logic [W-1:0]       x;
    logic [W-1:0]       y;
    logic               mode;
    logic [TAG_W-1:0]   tag_in;
    logic               out_valid;
    logic               out_ready;
    logic [2*W-1:0]     z;
    logic [TAG_W-1:0]   tag_out;
    logic               mismatch;
    logic [CNT_W-1:0]   err_cnt;
    logic               cnt_clr;

    modport master (
        output in_valid, x, y, mode, tag_in, out_ready, cnt_clr,
        input  in_ready, out_valid, z, tag_out, mismatch, err_cnt
    );

    modport slave (
        input  in_valid, x, y, mode, tag_in, out_ready, cnt_clr,
        output in_ready, out_valid, z, tag_out, mismatch, err_cnt
    );
endinterface

// File: rtl/approx_mult_pipe.sv
// Two-stage unsigned WxW multiplier with a per-transaction exact/approximate
// mode. Approximate mode drops the partial-product bits of the L low x rows
// that fall below column KEEP_COL. Stage 1 splits the product into the high
// rows, the truncated low rows and the exact low rows; stage 2 picks the sum
// and flags whether truncation changed the result. A saturating counter
// tracks how many delivered results were inexact.
module approx_mult_pipe #(
    parameter int W        = 8,
    parameter int L        = 2,
    parameter int KEEP_COL = 6,
    parameter int TAG_W    = 4,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    approx_mult_pipe_if.slave bus
);

    // Sum of the low-row partial-product bits that survive truncation.
    function automatic logic [2*W-1:0] f_trunc_rows(
        input logic [W-1:0] a_x,
        input logic [W-1:0] a_y
    );
        logic [2*W-1:0] v_sum;
        v_sum = '0;
        for (int i = 0; i < L; i++) begin
            for (int j = 0; j < W; j++) begin
                if ((i + j) >= KEEP_COL && a_x[i] && a_y[j]) begin
                    v_sum = v_sum + ((2*W)'(1) << (i + j));
                end
            end
        end
        return v_sum;
    endfunction

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] f_sat_inc(input logic [CNT_W-1:0] a_cnt);
        return (a_cnt == {CNT_W{1'b1}}) ? a_cnt : a_cnt + 1'b1;
    endfunction

    logic [2*W-1:0]   w_y_ext;
    logic [2*W-1:0]   w_xh_ext;
    logic [2*W-1:0]   w_xl_ext;
    logic [2*W-1:0]   w_p_hi;
    logic [2*W-1:0]   w_c;
    logic [2*W-1:0]   w_e_lo;
    logic             w_s2_adv;
    logic             w_s1_adv;
    logic             w_accept;
    logic             w_out_hs;

    logic [2*W-1:0]   r_p_hi_p1;
    logic [2*W-1:0]   r_c_p1;
    logic [2*W-1:0]   r_e_lo_p1;
    logic             r_mode_p1;
    logic [TAG_W-1:0] r_tag_p1;
    logic             r_vld_p1;

    logic [2*W-1:0]   r_z_p2;
    logic [TAG_W-1:0] r_tag_p2;
    logic             r_mis_p2;
    logic             r_vld_p2;

    logic [CNT_W-1:0] r_err_cnt;

    // Stage 0: operand decomposition into high rows, truncated and exact low rows
    assign w_y_ext  = {{W{1'b0}}, bus.y};
    assign w_xh_ext = (2*W)'(bus.x[W-1:L]);
    assign w_xl_ext = (2*W)'(bus.x[L-1:0]);
    assign w_p_hi   = (w_y_ext * w_xh_ext) << L;
    assign w_e_lo   = w_y_ext * w_xl_ext;
    assign w_c      = f_trunc_rows(bus.x, bus.y);

    // Flow control: a stage moves when it is empty or the stage after it moves.
    assign w_s2_adv     = !r_vld_p2 || bus.out_ready;
    assign w_s1_adv     = !r_vld_p1 || w_s2_adv;
    assign w_accept     = bus.in_valid && w_s1_adv;
    assign w_out_hs     = r_vld_p2 && bus.out_ready;
    assign bus.in_ready = w_s1_adv;

    // Stage 1 occupancy flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_p1 <= 1'b0;
        end else if (w_s1_adv) begin
            r_vld_p1 <= w_accept;
        end
    end

    // Stage 1 data capture on accept; contents are don't-care while empty.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_p_hi_p1 <= w_p_hi;
            r_c_p1    <= w_c;
            r_e_lo_p1 <= w_e_lo;
            r_mode_p1 <= bus.mode;
            r_tag_p1  <= bus.tag_in;
        end
    end

    // Stage 2: final sum, mismatch flag and tag; holds while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_p2 <= 1'b0;
            r_z_p2   <= '0;
            r_tag_p2 <= '0;
            r_mis_p2 <= 1'b0;
        end else if (w_s2_adv) begin
            r_vld_p2 <= r_vld_p1;
            if (r_vld_p1) begin
                r_z_p2   <= r_mode_p1 ? (r_p_hi_p1 + r_e_lo_p1) : (r_p_hi_p1 + r_c_p1);
                r_tag_p2 <= r_tag_p1;
                r_mis_p2 <= !r_mode_p1 && (r_c_p1 != r_e_lo_p1);
            end
        end
    end

    // Mismatch statistics: clear wins over a same-cycle counted delivery.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_cnt <= '0;
        end else if (bus.cnt_clr) begin
            r_err_cnt <= '0;
        end else if (w_out_hs && r_mis_p2) begin
            r_err_cnt <= f_sat_inc(r_err_cnt);
        end
    end

    assign bus.out_valid = r_vld_p2;
    assign bus.z         = r_z_p2;
    assign bus.tag_out   = r_tag_p2;
    assign bus.mismatch  = r_mis_p2;
    assign bus.err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_approx_mult_pipe.sv
// Bench for approx_mult_pipe: randomized and directed traffic scored against
// a behavioural model (exact product minus the dropped low-row bits). A
// second instance with a 2-bit counter shares the stimulus to exercise
// saturation.
module tb_approx_mult_pipe;

    localparam int W        = 8;
    localparam int L        = 2;
    localparam int KEEP_COL = 6;
    localparam int TAG_W    = 4;

    typedef struct {
        logic [15:0] z;
        logic [3:0]  tag;
        logic        mis;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    approx_mult_pipe_if #(.W(W), .TAG_W(TAG_W), .CNT_W(16)) bus ();
    approx_mult_pipe_if #(.W(W), .TAG_W(TAG_W), .CNT_W(2))  bus_s ();

    approx_mult_pipe #(.W(W), .L(L), .KEEP_COL(KEEP_COL), .TAG_W(TAG_W), .CNT_W(16)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    approx_mult_pipe #(.W(W), .L(L), .KEEP_COL(KEEP_COL), .TAG_W(TAG_W), .CNT_W(2)) u_dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (bus_s.slave)
    );

    assign bus_s.in_valid  = bus.in_valid;
    assign bus_s.x         = bus.x;
    assign bus_s.y         = bus.y;
    assign bus_s.mode      = bus.mode;
    assign bus_s.tag_in    = bus.tag_in;
    assign bus_s.out_ready = bus.out_ready;
    assign bus_s.cnt_clr   = bus.cnt_clr;

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_err = 0;
    exp_t        q[$];
    exp_t        cur_exp;
    int unsigned m_cnt = 0;
    bit          hold_pend = 0;
    logic [15:0] hold_z;
    logic [3:0]  hold_tag;
    logic        hold_mis;
    bit          acc_d1 = 0;
    bit          acc_d2 = 0;
    bit          lat_en = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int unsigned sat_cnt(input int unsigned c, input int unsigned mx);
        return (c > mx) ? mx : c;
    endfunction

    // Approximate product = exact product minus every low-row bit below KEEP_COL.
    function automatic void ref_mult(input int unsigned a, input int unsigned b, input bit md,
                                     output int unsigned p, output bit mis);
        int unsigned drop;
        drop = 0;
        if (!md) begin
            for (int i = 0; i < L; i++) begin
                if (((a >> i) & 1) != 0 && (KEEP_COL - i) > 0)
                    drop += (b % (32'd1 << (KEEP_COL - i))) << i;
            end
        end
        p   = a * b - drop;
        mis = (drop != 0);
    endfunction

    task automatic drive(input bit v, input int unsigned a, input int unsigned b,
                         input bit md, input int unsigned tg);
        int unsigned p;
        bit          mis;
        bus.in_valid = v;
        bus.x        = a[7:0];
        bus.y        = b[7:0];
        bus.mode     = md;
        bus.tag_in   = tg[3:0];
        ref_mult(a & 32'hFF, b & 32'hFF, md, p, mis);
        cur_exp.z   = p[15:0];
        cur_exp.tag = tg[3:0];
        cur_exp.mis = mis;
    endtask

    task automatic drive_exp(input int unsigned a, input int unsigned b, input bit md,
                             input int unsigned tg, input int unsigned ez, input bit emis);
        bus.in_valid = 1'b1;
        bus.x        = a[7:0];
        bus.y        = b[7:0];
        bus.mode     = md;
        bus.tag_in   = tg[3:0];
        cur_exp.z    = ez[15:0];
        cur_exp.tag  = tg[3:0];
        cur_exp.mis  = emis;
    endtask

    // One clock: score outputs at the falling edge, then advance past the rising edge.
    task automatic cycle();
        bit   acc;
        bit   hs;
        bit   hs_mis;
        exp_t e;
        @(negedge clk);
        chk("err_cnt", 32'(bus.err_cnt), sat_cnt(m_cnt, 65535));
        chk("err_cnt_sat", 32'(bus_s.err_cnt), sat_cnt(m_cnt, 3));
        chk("in_ready", 32'(bus.in_ready), 32'((q.size() < 2) || bus.out_ready));
        if (hold_pend) begin
            chk("hold_valid", 32'(bus.out_valid), 1);
            chk("hold_z", 32'(bus.z), 32'(hold_z));
            chk("hold_tag", 32'(bus.tag_out), 32'(hold_tag));
            chk("hold_mis", 32'(bus.mismatch), 32'(hold_mis));
        end
        if (lat_en) chk("latency", 32'(bus.out_valid), 32'(acc_d2));
        hs     = bus.out_valid && bus.out_ready;
        hs_mis = 0;
        if (hs) begin
            if (q.size() == 0) begin
                chk("spurious_out", 1, 0);
            end else begin
                e = q.pop_front();
                chk("z", 32'(bus.z), 32'(e.z));
                chk("tag_out", 32'(bus.tag_out), 32'(e.tag));
                chk("mismatch", 32'(bus.mismatch), 32'(e.mis));
                hs_mis = e.mis;
            end
        end
        if (bus.cnt_clr) m_cnt = 0;
        else if (hs_mis) m_cnt++;
        hold_pend = bus.out_valid && !bus.out_ready;
        hold_z    = bus.z;
        hold_tag  = bus.tag_out;
        hold_mis  = bus.mismatch;
        acc = bus.in_valid && bus.in_ready;
        if (acc) q.push_back(cur_exp);
        acc_d2 = acc_d1;
        acc_d1 = acc;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.cnt_clr  = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        idle();
        bus.out_ready = 1'b1;
        while (q.size() != 0 && n < budget) begin
            cycle();
            n++;
        end
        chk("drain_timeout", q.size(), 0);
    endtask

    task automatic do_reset();
        idle();
        bus.out_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_z", 32'(bus.z), 0);
        chk("rst_tag", 32'(bus.tag_out), 0);
        chk("rst_mis", 32'(bus.mismatch), 0);
        chk("rst_err_cnt", 32'(bus.err_cnt), 0);
        q.delete();
        hold_pend = 0;
        acc_d1    = 0;
        acc_d2    = 0;
        m_cnt     = 0;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_in_ready", 32'(bus.in_ready), 1);
        chk("rst_out_valid_rel", 32'(bus.out_valid), 0);
    endtask

    initial begin
        int unsigned a;
        int unsigned b;
        bus.in_valid  = 1'b0;
        bus.x         = '0;
        bus.y         = '0;
        bus.mode      = 1'b0;
        bus.tag_in    = '0;
        bus.out_ready = 1'b0;
        bus.cnt_clr   = 1'b0;
        cur_exp       = '{z: 16'd0, tag: 4'd0, mis: 1'b0};

        repeat (3) @(posedge clk);
        #1;
        do_reset();

        // Reset with two transactions in flight: neither may ever appear.
        bus.out_ready = 1'b1;
        drive(1, 3, 3, 0, 9);
        cycle();
        drive(1, 255, 255, 1, 10);
        cycle();
        do_reset();
        bus.out_ready = 1'b1;
        idle();
        repeat (4) cycle();
        chk("post_rst_err", 32'(bus.err_cnt), 0);

        // Directed corner products.
        drive_exp(255, 255, 0, 5, 64900, 1);
        cycle();
        drain(20);
        chk("cnt_one", 32'(bus.err_cnt), 1);
        drive_exp(255, 255, 1, 6, 65025, 0);
        cycle();
        drive_exp(3, 3, 0, 7, 0, 1);
        cycle();
        drive_exp(4, 200, 0, 8, 800, 0);
        cycle();
        drain(20);
        chk("cnt_two", 32'(bus.err_cnt), 2);

        // Full-rate stream of 16 with fixed two-edge latency.
        lat_en = 1;
        bus.out_ready = 1'b1;
        for (int t = 0; t < 16; t++) begin
            drive(1, $urandom_range(0, 255), $urandom_range(0, 255), 1'($urandom_range(0, 1)), t);
            cycle();
        end
        idle();
        repeat (3) cycle();
        lat_en = 0;
        chk("stream_left", q.size(), 0);

        // Backpressure: hold out_ready low for 5 cycles while pushing.
        bus.out_ready = 1'b0;
        for (int t = 0; t < 5; t++) begin
            drive(1, $urandom_range(0, 255), $urandom_range(0, 255), 1'b0, t + 3);
            cycle();
        end
        chk("stall_occupancy", q.size(), 2);
        drain(20);

        // Counter saturation on the 2-bit instance, then clear collision.
        bus.cnt_clr = 1'b1;
        bus.in_valid = 1'b0;
        cycle();
        bus.cnt_clr = 1'b0;
        bus.out_ready = 1'b1;
        for (int t = 0; t < 5; t++) begin
            drive_exp(3, 3, 0, t, 0, 1);
            cycle();
        end
        drain(20);
        chk("sat_cnt3", 32'(bus_s.err_cnt), 3);
        chk("cnt_five", 32'(bus.err_cnt), 5);
        bus.out_ready = 1'b0;
        drive_exp(3, 3, 0, 12, 0, 1);
        cycle();
        idle();
        repeat (2) cycle();
        bus.cnt_clr   = 1'b1;
        bus.out_ready = 1'b1;
        cycle();
        bus.cnt_clr = 1'b0;
        chk("clr_prio", 32'(bus.err_cnt), 0);
        chk("clr_prio_sat", 32'(bus_s.err_cnt), 0);
        drain(20);

        // Randomized traffic with random backpressure and occasional clears.
        for (int t = 0; t < 600; t++) begin
            case ($urandom_range(0, 5))
                0: a = 255;
                1: a = $urandom_range(0, 3);
                default: a = $urandom_range(0, 255);
            endcase
            case ($urandom_range(0, 5))
                0: b = 255;
                1: b = $urandom_range(0, 63);
                default: b = $urandom_range(0, 255);
            endcase
            drive($urandom_range(0, 3) != 0, a, b, 1'($urandom_range(0, 1)), $urandom_range(0, 15));
            bus.out_ready = ($urandom_range(0, 9) < 7);
            bus.cnt_clr   = ($urandom_range(0, 49) == 0);
            cycle();
        end
        drain(20);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
